// File: rtl/sp_pkt_pkg.sv
// Shared types and helpers for the strict-priority packet-lock multiplexer
// and other arbitration blocks: FSM state, index width, priority pick.
package sp_pkt_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Widest request vector the shared pick function handles.
  localparam int MAX_NUM = 64;

  function automatic int idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot pick of the highest-priority set bit among the low num bits of req.
  function automatic logic [MAX_NUM-1:0] prio_pick(
    input logic [MAX_NUM-1:0] req,
    input int                 num,
    input bit                 lsb_high
  );
    logic [MAX_NUM-1:0] gnt;
    bit                 found;
    gnt   = '0;
    found = 1'b0;
    if (lsb_high) begin
      for (int i = 0; i < MAX_NUM; i++) begin
        if (!found && (i < num) && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = MAX_NUM - 1; i >= 0; i--) begin
        if (!found && (i < num) && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/sp_pkt_lock_mux_onehot2idx.sv
// One-hot to binary index encoder; selects the locked source's data and
// provides the source index reported alongside each output beat.
module onehot2idx #(
  parameter int NUM  = 4,
  parameter int IDXW = 2
) (
  input  logic [NUM-1:0]  onehot,
  output logic [IDXW-1:0] idx
);

  logic [NUM-1:0] terms [IDXW];

  // Index bit b is the OR of every one-hot bit whose position has bit b set.
  genvar gi, gj;
  generate
    for (gi = 0; gi < IDXW; gi++) begin : g_bit
      for (gj = 0; gj < NUM; gj++) begin : g_src
        assign terms[gi][gj] = onehot[gj] & (((gj >> gi) & 1) == 1);
      end
      assign idx[gi] = |terms[gi];
    end
  endgenerate

endmodule

// File: rtl/sp_pkt_lock_mux.sv
// N:1 strict-priority packet multiplexer with grant lock until last beat and
// a registered output stage. Optional per-source packet counters: SP_PKT_LOCK_MUX_CNT_EN.
module sp_pkt_lock_mux
  import sp_pkt_pkg::*;
#(
  parameter int NUM      = 4,
  parameter int DW       = 32,
  parameter bit LSB_HIGH = 1'b1,
  parameter int CNT_W    = 16,
  localparam int IDXW    = idxw(NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM-1:0]    in_valid,
  input  logic [NUM*DW-1:0] in_data,
  input  logic [NUM-1:0]    in_last,
  output logic [NUM-1:0]    in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [IDXW-1:0]   out_src,
  input  logic              out_ready,
`ifdef SP_PKT_LOCK_MUX_CNT_EN
  output logic [NUM*CNT_W-1:0] pkt_cnt,
`endif
  output logic [NUM-1:0]    lock_gnt
);

  state_t          state_reg, state_next;
  logic [NUM-1:0]  lock_gnt_reg, lock_gnt_next;
  logic [NUM-1:0]  pick;
  logic [IDXW-1:0] gnt_idx;
  logic [DW-1:0]   src_data [NUM];
  logic [DW-1:0]   sel_data;
  logic            sel_last;
  logic            accept;

  logic            out_valid_reg;
  logic [DW-1:0]   out_data_reg;
  logic            out_last_reg;
  logic [IDXW-1:0] out_src_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_unpack
      assign src_data[gi] = in_data[gi*DW +: DW];
    end
  endgenerate

  assign pick = NUM'(prio_pick(MAX_NUM'(in_valid), NUM, LSB_HIGH));

  onehot2idx #(
    .NUM  (NUM),
    .IDXW (IDXW)
  ) u_enc (
    .onehot (lock_gnt_reg),
    .idx    (gnt_idx)
  );

  assign sel_data = src_data[gnt_idx];
  assign sel_last = in_last[gnt_idx];

  // The granted source may push whenever the output register is empty or draining.
  assign in_ready = (state_reg == LOCKED)
                  ? (lock_gnt_reg & {NUM{~out_valid_reg | out_ready}})
                  : '0;
  assign accept   = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      lock_gnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_gnt_reg <= lock_gnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lock_gnt_next = lock_gnt_reg;
    case (state_reg)
      IDLE: begin
        if (|in_valid) begin
          state_next    = LOCKED;
          lock_gnt_next = pick;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_next    = IDLE;
          lock_gnt_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        lock_gnt_next = '0;
      end
    endcase
  end

  // Output register: load on accept, empty on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_src_reg   <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= sel_data;
      out_last_reg  <= sel_last;
      out_src_reg   <= gnt_idx;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_src   = out_src_reg;
  assign lock_gnt  = lock_gnt_reg;

`ifdef SP_PKT_LOCK_MUX_CNT_EN
  logic [CNT_W-1:0] cnt_reg [NUM];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM; i++) begin
      if (rst) begin
        cnt_reg[i] <= '0;
      end else if (accept && sel_last && lock_gnt_reg[i]) begin
        cnt_reg[i] <= cnt_reg[i] + 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM; gi++) begin : g_cnt
      assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
    end
  endgenerate
`endif

endmodule
